// File: rtl/out_display_7seg.sv
// Byte-to-decimal display back-end: double-dabble converter
// feeding a 4-digit multiplexed common-anode 7-segment display.
module out_display_7seg #(
  parameter int REFRESH_DIV = 50000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] value,
  input  logic       signed_mode,
  output logic [6:0] seg,
  output logic [3:0] an,
  output logic       dp,
  output logic       busy
);

  localparam int RW = $clog2(REFRESH_DIV);
  localparam logic [RW-1:0] RMAX = RW'(REFRESH_DIV - 1);

  localparam logic [6:0] SEG_DASH  = 7'h3F;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  typedef enum logic {IDLE, CONV} state_t;

  state_t state, state_nxt;

  logic       cap_sm;
  logic [7:0] cap_val;
  logic [7:0] mag;
  logic [11:0] bcd;
  logic [2:0] iter;
  logic       pend_neg;

  logic [3:0] hund, tens, ones;
  logic       neg;

  logic [RW-1:0] rcnt;
  logic [1:0]    idx;

  logic       mismatch;
  logic       last;
  logic       in_neg;
  logic [7:0] in_mag;
  logic [11:0] adj;
  logic [11:0] bcd_sh;
  logic [7:0] mag_sh;
  logic [6:0] digit_seg;

  function automatic logic [3:0] add3(input logic [3:0] n);
    return (n >= 4'd5) ? n + 4'd3 : n;
  endfunction

  function automatic logic [6:0] dec7(input logic [3:0] d);
    logic [6:0] s;
    s = SEG_BLANK;
    case (d)
      4'd0: s = 7'h40;
      4'd1: s = 7'h79;
      4'd2: s = 7'h24;
      4'd3: s = 7'h30;
      4'd4: s = 7'h19;
      4'd5: s = 7'h12;
      4'd6: s = 7'h02;
      4'd7: s = 7'h78;
      4'd8: s = 7'h00;
      4'd9: s = 7'h10;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

  assign mismatch = {signed_mode, value} != {cap_sm, cap_val};
  assign last     = (iter == 3'd7);
  assign in_neg   = signed_mode & value[7];
  assign in_mag   = in_neg ? (~value + 8'd1) : value;
  assign adj      = {add3(bcd[11:8]), add3(bcd[7:4]), add3(bcd[3:0])};
  assign bcd_sh   = {adj[10:0], mag[7]};
  assign mag_sh   = {mag[6:0], 1'b0};
  assign busy     = (state == CONV);
  assign dp       = 1'b1;

  // Converter state register
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next state: start on input change, finish after 8 iterations
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (mismatch) state_nxt = CONV;
      CONV: if (last)     state_nxt = IDLE;
    endcase
  end

  // Capture, shift-add-3 iterations and display register update
  always_ff @(posedge clk) begin
    if (reset) begin
      cap_sm   <= 1'b0;
      cap_val  <= 8'h00;
      mag      <= 8'h00;
      bcd      <= 12'h000;
      iter     <= 3'd0;
      pend_neg <= 1'b0;
      hund     <= 4'd0;
      tens     <= 4'd0;
      ones     <= 4'd0;
      neg      <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (mismatch) begin
            cap_sm   <= signed_mode;
            cap_val  <= value;
            mag      <= in_mag;
            pend_neg <= in_neg;
            bcd      <= 12'h000;
            iter     <= 3'd0;
          end
        end
        CONV: begin
          mag  <= mag_sh;
          bcd  <= bcd_sh;
          iter <= iter + 3'd1;
          if (last) begin
            hund <= bcd_sh[11:8];
            tens <= bcd_sh[7:4];
            ones <= bcd_sh[3:0];
            neg  <= pend_neg;
          end
        end
      endcase
    end
  end

  // Segment pattern for the currently selected digit, with blanking
  always_comb begin
    digit_seg = SEG_BLANK;
    unique case (idx)
      2'd0: digit_seg = dec7(ones);
      2'd1: digit_seg = (hund == 4'd0 && tens == 4'd0) ? SEG_BLANK
                                                        : dec7(tens);
      2'd2: digit_seg = (hund == 4'd0) ? SEG_BLANK : dec7(hund);
      2'd3: digit_seg = neg ? SEG_DASH : SEG_BLANK;
    endcase
  end

  // Refresh counter, digit scan and registered anode/segment drive
  always_ff @(posedge clk) begin
    if (reset) begin
      rcnt <= '0;
      idx  <= 2'd0;
      an   <= 4'hF;
      seg  <= SEG_BLANK;
    end else begin
      if (rcnt == RMAX) begin
        rcnt <= '0;
        idx  <= idx + 2'd1;
      end else begin
        rcnt <= rcnt + 1'b1;
      end
      an  <= ~(4'b0001 << idx);
      seg <= digit_seg;
    end
  end

endmodule

// File: tb/tb_out_display_7seg.sv
// Directed self-checking bench for out_display_7seg
// using REFRESH_DIV=4 so a full scan frame is 16 cycles.
module tb_out_display_7seg;

  localparam logic [6:0] S0 = 7'h40;
  localparam logic [6:0] S1 = 7'h79;
  localparam logic [6:0] S2 = 7'h24;
  localparam logic [6:0] S5 = 7'h12;
  localparam logic [6:0] S8 = 7'h00;
  localparam logic [6:0] SD = 7'h3F;
  localparam logic [6:0] SB = 7'h7F;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] value;
  logic       signed_mode;
  logic [6:0] seg;
  logic [3:0] an;
  logic       dp;
  logic       busy;

  int checks = 0;
  int errors = 0;

  out_display_7seg #(.REFRESH_DIV(4)) dut (
    .clk(clk),
    .reset(reset),
    .value(value),
    .signed_mode(signed_mode),
    .seg(seg),
    .an(an),
    .dp(dp),
    .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [7:0] obs,
                     input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Checks n consecutive cycles against a 4-digit expected image.
  task automatic check_frame(input logic [6:0] e3,
                             input logic [6:0] e2,
                             input logic [6:0] e1,
                             input logic [6:0] e0,
                             input logic eb,
                             input int n);
    logic [6:0] e;
    logic ok;
    for (int i = 0; i < n; i++) begin
      e = SB;
      ok = 1'b1;
      case (an)
        4'b1110: e = e0;
        4'b1101: e = e1;
        4'b1011: e = e2;
        4'b0111: e = e3;
        default: ok = 1'b0;
      endcase
      chk("an_onehot", {7'b0, ok}, 8'd1);
      chk("seg", {1'b0, seg}, {1'b0, e});
      chk("busy", {7'b0, busy}, {7'b0, eb});
      @(negedge clk);
    end
  endtask

  initial begin
    reset = 1'b1;
    value = 8'h00;
    signed_mode = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_an", {4'b0, an}, 8'h0F);
    chk("rst_seg", {1'b0, seg}, 8'h7F);
    chk("rst_dp", {7'b0, dp}, 8'd1);
    chk("rst_busy", {7'b0, busy}, 8'd0);

    // Release: scan sequence, each digit lit for 4 cycles
    reset = 1'b0;
    @(negedge clk);
    for (int k = 1; k <= 16; k++) begin
      chk("scan_an", {4'b0, an},
          {4'b0, ~(4'b0001 << ((k - 1) / 4))});
      chk("scan_seg", {1'b0, seg}, (k <= 4) ? 8'h40 : 8'h7F);
      chk("scan_busy", {7'b0, busy}, 8'd0);
      @(negedge clk);
    end

    // 0xFF unsigned -> " 255"
    value = 8'hFF;
    signed_mode = 1'b0;
    @(posedge clk);
    @(negedge clk);
    for (int k = 0; k <= 8; k++) begin
      chk("ff_busy", {7'b0, busy}, (k <= 7) ? 8'd1 : 8'd0);
      @(negedge clk);
    end
    check_frame(SB, S2, S5, S5, 1'b0, 16);

    // 0xFF signed -> "-  1"
    signed_mode = 1'b1;
    @(posedge clk);
    @(negedge clk);
    for (int k = 0; k <= 8; k++) begin
      chk("ffs_busy", {7'b0, busy}, (k <= 7) ? 8'd1 : 8'd0);
      @(negedge clk);
    end
    check_frame(SD, SB, SB, S1, 1'b0, 16);

    // 0x80 signed -> "-128"
    value = 8'h80;
    @(posedge clk);
    @(negedge clk);
    for (int k = 0; k <= 8; k++) begin
      chk("80s_busy", {7'b0, busy}, (k <= 7) ? 8'd1 : 8'd0);
      @(negedge clk);
    end
    check_frame(SD, S1, S2, S8, 1'b0, 16);

    // 0x05 then 0x0A mid-conversion: back-to-back, no partial digits
    value = 8'h05;
    signed_mode = 1'b0;
    @(posedge clk);
    @(negedge clk);
    for (int k = 0; k <= 21; k++) begin
      if (k == 2) value = 8'h0A;
      if (k <= 8)
        check_frame(SD, S1, S2, S8,
                    (k <= 7) ? 1'b1 : 1'b0, 1);
      else if (k <= 17)
        check_frame(SB, SB, SB, S5,
                    (k <= 16) ? 1'b1 : 1'b0, 1);
      else
        check_frame(SB, SB, S1, S0, 1'b0, 1);
    end
    check_frame(SB, SB, S1, S0, 1'b0, 16);

    // Reset during conversion of 0x63 discards the partial result
    value = 8'h63;
    @(posedge clk);
    @(negedge clk);
    for (int k = 0; k <= 3; k++) begin
      chk("63_busy", {7'b0, busy}, 8'd1);
      if (k < 3) @(negedge clk);
    end
    reset = 1'b1;
    value = 8'h00;
    @(negedge clk);
    chk("mid_rst_an", {4'b0, an}, 8'h0F);
    chk("mid_rst_seg", {1'b0, seg}, 8'h7F);
    chk("mid_rst_busy", {7'b0, busy}, 8'd0);
    reset = 1'b0;
    @(negedge clk);
    chk("post_rst_an", {4'b0, an}, 8'h0E);
    check_frame(SB, SB, SB, S0, 1'b0, 20);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
